// File: rtl/pixel_frame_streamer_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : pfs_pkg
//  Description : Shared types and constants for pixel_frame_streamer.
//                Provides the controller state encoding, the default frame
//                geometry and a clog2 helper that never returns zero.
//                NPIX, ADDR_W and PIXW_T describe the default configuration.
//                Modules derive their own sizes from their parameters.
//  Revision    : 1.0 - initial release
// ============================================================================
package pfs_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        STREAM   = 2'd1,
        WAIT_RES = 2'd2
    } state_t;

    // Bit width needed to index v items. The result is at least 1, so a
    // degenerate dimension still gets a legal vector.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

    localparam int DEF_PIX_W    = 8;
    localparam int DEF_CHANNELS = 1;
    localparam int DEF_IMG_W    = 40;
    localparam int DEF_IMG_H    = 40;
    localparam int DEF_RES_W    = 8;
    localparam int DEF_TIMEOUT  = 65535;

    localparam int NPIX   = DEF_IMG_W * DEF_IMG_H;
    localparam int ADDR_W = clog2_min1(NPIX);
    localparam int PIXW_T = DEF_PIX_W * DEF_CHANNELS;

endpackage
`default_nettype wire

// File: rtl/pixel_frame_streamer_if.sv
`default_nettype none
// ============================================================================
//  Interface   : pixel_frame_streamer_if
//  Description : Pixel stream with valid/ready handshake and frame markers.
//    pix_data  - pixel; channel 0 sits in the LSBs
//    pix_valid - the source holds a pixel
//    pix_ready - the sink accepts the pixel; transfer on valid & ready
//    pix_sof   - first pixel of the frame
//    pix_eol   - last pixel of a row
//    pix_last  - last pixel of the frame
//  Modports    : master (source side) and slave (sink side)
//  Revision    : 1.0 - initial release
// ============================================================================
interface pixel_frame_streamer_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] pix_data;
    logic              pix_valid;
    logic              pix_ready;
    logic              pix_sof;
    logic              pix_eol;
    logic              pix_last;

    modport master (
        output pix_data, pix_valid, pix_sof, pix_eol, pix_last,
        input  pix_ready
    );

    modport slave (
        input  pix_data, pix_valid, pix_sof, pix_eol, pix_last,
        output pix_ready
    );
endinterface
`default_nettype wire

// File: rtl/pixel_frame_streamer_frame_buffer_ram.sv
`default_nettype none
// ============================================================================
//  Module      : frame_buffer_ram
//  Description : Simple dual-port frame store. It has one write port and one
//                read port, and the read data is registered (1-cycle latency).
//                Memory contents are not reset.
//  Ports       : clk      - clock
//                we_i     - write strobe
//                waddr_i  - write address (writes at or above DEPTH dropped)
//                wdata_i  - write data
//                re_i     - read enable
//                raddr_i  - read address
//                rdata_o  - registered read data
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_buffer_ram
    import pfs_pkg::*;
#(
    parameter int DATA_W = PIXW_T,
    parameter int DEPTH  = NPIX,
    parameter int AW     = ADDR_W
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic              w_wr_ok;

    // The address space rounds up to a power of two. Writes outside the
    // frame are dropped so they cannot alias onto real pixels.
    assign w_wr_ok = we_i && ({1'b0, waddr_i} < c_DEPTH);

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/pixel_frame_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_frame_streamer
//  Description : Holds one multi-channel frame and streams it pixel by pixel.
//                The stream uses valid/ready backpressure and carries SOF,
//                EOL and LAST markers. After the last pixel the block waits
//                for the network result and captures it. A timeout limits
//                the wait.
//  Ports       : clk, rst          - clock, asynchronous active-high reset
//                load_we_i/addr/data - frame buffer write port (IDLE only)
//                start_i           - pulse: stream the buffered frame
//                busy_o            - high from accepted start to done/timeout
//                pix_if            - pixel stream, master side
//                res_i, res_valid_i - network result and its strobe
//                result_o          - captured result, held until next capture
//                result_valid_o    - 1-cycle capture pulse (done)
//                timeout_o         - 1-cycle pulse when the wait expires
//  Revision    : 1.0 - initial release
// ============================================================================
module pixel_frame_streamer
    import pfs_pkg::*;
#(
    parameter int PIX_W    = DEF_PIX_W,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int IMG_W    = DEF_IMG_W,
    parameter int IMG_H    = DEF_IMG_H,
    parameter int RES_W    = DEF_RES_W,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 load_we_i,
    input  logic [clog2_min1(IMG_W*IMG_H)-1:0]   load_addr_i,
    input  logic [PIX_W*CHANNELS-1:0]            load_data_i,
    input  logic                                 start_i,
    output logic                                 busy_o,
    pixel_frame_streamer_if.master               pix_if,
    input  logic [RES_W-1:0]                     res_i,
    input  logic                                 res_valid_i,
    output logic [RES_W-1:0]                     result_o,
    output logic                                 result_valid_o,
    output logic                                 timeout_o
);
    localparam int c_NPIX   = IMG_W * IMG_H;
    localparam int c_ADDR_W = clog2_min1(c_NPIX);
    localparam int c_PIXW_T = PIX_W * CHANNELS;
    localparam int c_ENT_W  = c_PIXW_T + 3;   // {last, eol, sof, data}
    localparam int c_X_W    = clog2_min1(IMG_W);
    localparam int c_Y_W    = clog2_min1(IMG_H);
    localparam int c_CNT_W  = clog2_min1(TIMEOUT);

    localparam logic [c_X_W-1:0]   c_X_LAST   = c_X_W'(IMG_W - 1);
    localparam logic [c_Y_W-1:0]   c_Y_LAST   = c_Y_W'(IMG_H - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    state_t               state_q;
    logic                 busy_q;
    logic                 fetch_done_q;
    logic [c_ADDR_W-1:0]  addr_q;
    logic [c_X_W-1:0]     x_q;
    logic [c_Y_W-1:0]     y_q;
    logic [c_CNT_W-1:0]   wait_cnt_q;
    logic [RES_W-1:0]     result_q;
    logic                 result_valid_q;
    logic                 timeout_q;

    // ------------------------------------------------------------------
    // Stream pipeline: RAM read stage -> output register + skid entry
    // ------------------------------------------------------------------
    logic                 rd_vld_q;
    logic [2:0]           rd_mk_q;
    logic                 out_vld_q;
    logic [c_ENT_W-1:0]   out_q;
    logic                 sk_vld_q;
    logic [c_ENT_W-1:0]   sk_q;

    logic [c_PIXW_T-1:0]  w_ram_rdata;
    logic [c_ENT_W-1:0]   w_rd_ent;
    logic                 w_ram_we;
    logic                 w_pop;
    logic                 w_last_hs;
    logic [1:0]           w_occ;
    logic                 w_issue;
    logic                 w_sof;
    logic                 w_eol;
    logic                 w_last;

    assign w_ram_we  = load_we_i && (state_q == IDLE);
    assign w_pop     = out_vld_q && pix_if.pix_ready;
    assign w_last_hs = w_pop && out_q[c_PIXW_T+2];

    // Up to three pixels can be in flight: the RAM read, the output register
    // and the skid entry. A read is issued only if the pixel it returns next
    // cycle will find a free slot. With ready held high the block still
    // moves one pixel per cycle.
    assign w_occ   = 2'(out_vld_q) + 2'(sk_vld_q) + 2'(rd_vld_q);
    assign w_issue = (state_q == STREAM) && !fetch_done_q
                     && ((w_occ - 2'(w_pop)) < 2'd2);

    // The markers are worked out when the read is issued. They travel
    // beside the RAM latency and join the data when it returns.
    assign w_sof  = (addr_q == '0);
    assign w_eol  = (x_q == c_X_LAST);
    assign w_last = w_eol && (y_q == c_Y_LAST);

    assign w_rd_ent = {rd_mk_q, w_ram_rdata};

    frame_buffer_ram #(
        .DATA_W (c_PIXW_T),
        .DEPTH  (c_NPIX),
        .AW     (c_ADDR_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (w_ram_we),
        .waddr_i (load_addr_i),
        .wdata_i (load_data_i),
        .re_i    (w_issue),
        .raddr_i (addr_q),
        .rdata_o (w_ram_rdata)
    );

    // ------------------------------------------------------------------
    // FSM, address generation and result wait
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            busy_q         <= 1'b0;
            fetch_done_q   <= 1'b0;
            addr_q         <= '0;
            x_q            <= '0;
            y_q            <= '0;
            wait_cnt_q     <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            result_valid_q <= 1'b0;
            timeout_q      <= 1'b0;

            if (w_issue) begin
                addr_q <= addr_q + c_ADDR_W'(1);
                if (w_eol) begin
                    x_q <= '0;
                    y_q <= w_last ? '0 : y_q + c_Y_W'(1);
                end else begin
                    x_q <= x_q + c_X_W'(1);
                end
                if (w_last) begin
                    fetch_done_q <= 1'b1;
                end
            end

            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q      <= STREAM;
                        busy_q       <= 1'b1;
                        fetch_done_q <= 1'b0;
                        addr_q       <= '0;
                        x_q          <= '0;
                        y_q          <= '0;
                    end
                end
                STREAM: begin
                    if (w_last_hs) begin
                        state_q    <= WAIT_RES;
                        wait_cnt_q <= '0;
                    end
                end
                WAIT_RES: begin
                    // If the result arrives in the same cycle as the
                    // timeout, the result is taken.
                    if (res_valid_i) begin
                        result_q       <= res_i;
                        result_valid_q <= 1'b1;
                        busy_q         <= 1'b0;
                        state_q        <= IDLE;
                    end else if (wait_cnt_q == c_CNT_LAST) begin
                        timeout_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + c_CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output register with a one-entry skid. The skid catches the read
    // that was already in flight when the sink stalled.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_vld_q  <= 1'b0;
            rd_mk_q   <= '0;
            out_vld_q <= 1'b0;
            out_q     <= '0;
            sk_vld_q  <= 1'b0;
            sk_q      <= '0;
        end else begin
            rd_vld_q <= w_issue;
            if (w_issue) begin
                rd_mk_q <= {w_last, w_eol, w_sof};
            end

            if (!out_vld_q || w_pop) begin
                if (sk_vld_q) begin
                    out_q     <= sk_q;
                    out_vld_q <= 1'b1;
                    sk_vld_q  <= rd_vld_q;
                    if (rd_vld_q) begin
                        sk_q <= w_rd_ent;
                    end
                end else if (rd_vld_q) begin
                    out_q     <= w_rd_ent;
                    out_vld_q <= 1'b1;
                end else begin
                    out_vld_q <= 1'b0;
                end
            end else if (rd_vld_q) begin
                sk_q     <= w_rd_ent;
                sk_vld_q <= 1'b1;
            end
        end
    end

    assign pix_if.pix_valid = out_vld_q;
    assign pix_if.pix_data  = out_q[c_PIXW_T-1:0];
    assign pix_if.pix_sof   = out_q[c_PIXW_T];
    assign pix_if.pix_eol   = out_q[c_PIXW_T+1];
    assign pix_if.pix_last  = out_q[c_PIXW_T+2];

    assign busy_o         = busy_q;
    assign result_o       = result_q;
    assign result_valid_o = result_valid_q;
    assign timeout_o      = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_pixel_frame_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pixel_frame_streamer
//  Description : Self-checking bench for pixel_frame_streamer. A reference
//                frame array holds what the frame buffer should contain.
//                Expected beats come from the frame geometry rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_frame_streamer;
    localparam int IMG_W = 40;
    localparam int IMG_H = 40;
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int AW    = 11;
    localparam int TO    = 100;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_we_i;
    logic [AW-1:0] load_addr_i;
    logic [7:0]    load_data_i;
    logic          start_i;
    logic          busy_o;
    logic [7:0]    res_i;
    logic          res_valid_i;
    logic [7:0]    result_o;
    logic          result_valid_o;
    logic          timeout_o;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] ref_mem [NPIX];
    bit         did_reset;

    always #5 clk = ~clk;

    pixel_frame_streamer_if #(.DATA_W(8)) pif ();

    pixel_frame_streamer #(
        .PIX_W(8), .CHANNELS(1), .IMG_W(IMG_W), .IMG_H(IMG_H),
        .RES_W(8), .TIMEOUT(TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .load_we_i      (load_we_i),
        .load_addr_i    (load_addr_i),
        .load_data_i    (load_data_i),
        .start_i        (start_i),
        .busy_o         (busy_o),
        .pix_if         (pif.master),
        .res_i          (res_i),
        .res_valid_i    (res_valid_i),
        .result_o       (result_o),
        .result_valid_o (result_valid_o),
        .timeout_o      (timeout_o)
    );

    task automatic load_frame(input bit ramp);
        for (int i = 0; i < NPIX; i++) begin
            @(negedge clk);
            load_we_i   = 1'b1;
            load_addr_i = AW'(i);
            load_data_i = ramp ? 8'(i % 256) : 8'($urandom);
            ref_mem[i]  = load_data_i;
        end
        @(negedge clk);
        load_we_i = 1'b0;
    endtask

    // Streams one frame, checks every beat against ref_mem, and returns at
    // the negedge just after the last handshake (or after a mid-frame reset).
    task automatic run_stream(input int ready_pct, input bit meddle,
                              input bit early_res, input int rst_at,
                              input bit co_write);
        int         beat = 0;
        int         guard = 0;
        int         n = 0;
        int         first_cyc = -1;
        int         last_cyc = 0;
        bit         prev_stall = 1'b0;
        bit         rv_seen = 1'b0;
        logic [11:0] saved = '0;
        logic [11:0] cur;
        logic [11:0] exp_v;
        logic [7:0]  res_before;
        res_before = result_o;

        @(negedge clk);
        start_i = 1'b1;
        if (co_write) begin
            load_we_i   = 1'b1;
            load_addr_i = '0;
            load_data_i = 8'($urandom);
            ref_mem[0]  = load_data_i;
        end
        @(negedge clk);
        start_i   = 1'b0;
        load_we_i = 1'b0;
        n_tests++;
        if (busy_o !== 1'b1) begin
            n_fail++; $display("FAIL busy_rise: got %b want 1", busy_o);
        end
        n_tests++;
        if (pif.pix_valid !== 1'b0) begin
            n_fail++; $display("FAIL valid_lat1: got %b want 0", pif.pix_valid);
        end
        @(negedge clk);
        n_tests++;
        if (pif.pix_valid !== 1'b0) begin
            n_fail++; $display("FAIL valid_lat2: got %b want 0", pif.pix_valid);
        end
        @(negedge clk);
        n_tests++;
        if (pif.pix_valid !== 1'b1) begin
            n_fail++; $display("FAIL valid_lat3: got %b want 1", pif.pix_valid);
        end

        while (beat < NPIX && guard < 20000) begin
            cur = {pif.pix_valid, pif.pix_sof, pif.pix_eol, pif.pix_last, pif.pix_data};
            if (prev_stall) begin
                n_tests++;
                if (cur !== saved) begin
                    n_fail++;
                    $display("FAIL stall_hold beat %0d: got %h want %h", beat, cur, saved);
                end
            end
            if (result_valid_o === 1'b1) rv_seen = 1'b1;
            if (rst_at >= 0 && beat == rst_at) begin
                pif.pix_ready = 1'b0;
                start_i       = 1'b0;
                load_we_i     = 1'b0;
                res_valid_i   = 1'b0;
                rst           = 1'b1;
                #1;
                n_tests++;
                if ({busy_o, pif.pix_valid, pif.pix_sof, pif.pix_eol, pif.pix_last,
                     pif.pix_data, result_o, result_valid_o, timeout_o} !== '0) begin
                    n_fail++;
                    $display("FAIL async_reset: busy=%b valid=%b data=%h result=%h want all 0",
                             busy_o, pif.pix_valid, pif.pix_data, result_o);
                end
                @(negedge clk);
                rst       = 1'b0;
                did_reset = 1'b1;
                return;
            end
            pif.pix_ready = ($urandom_range(99) < ready_pct);
            if (meddle) begin
                start_i     = ($urandom_range(3) == 0);
                load_we_i   = ($urandom_range(1) == 0);
                load_addr_i = AW'($urandom_range(NPIX - 1));
                load_data_i = 8'($urandom);
            end
            if (early_res) begin
                res_valid_i = ($urandom_range(1) == 0);
                res_i       = 8'($urandom);
            end
            if (pif.pix_valid === 1'b1 && first_cyc < 0) first_cyc = n;
            if (pif.pix_valid === 1'b1 && pif.pix_ready) begin
                exp_v = {1'b1, beat == 0, (beat % IMG_W) == IMG_W - 1,
                         beat == NPIX - 1, ref_mem[beat]};
                n_tests++;
                if (cur !== exp_v) begin
                    n_fail++;
                    $display("FAIL beat %0d: got {v,sof,eol,last,data}=%h want %h", beat, cur, exp_v);
                end
                last_cyc = n;
                beat++;
            end
            prev_stall = (pif.pix_valid === 1'b1) && !pif.pix_ready;
            saved      = cur;
            @(negedge clk);
            n++;
            guard++;
        end
        start_i     = 1'b0;
        load_we_i   = 1'b0;
        res_valid_i = 1'b0;

        n_tests++;
        if (beat != NPIX) begin
            n_fail++; $display("FAIL stream_budget: got %0d beats want %0d", beat, NPIX);
        end
        n_tests++;
        if (pif.pix_valid !== 1'b0) begin
            n_fail++; $display("FAIL valid_drop: got %b want 0", pif.pix_valid);
        end
        n_tests++;
        if (busy_o !== 1'b1) begin
            n_fail++; $display("FAIL busy_wait: got %b want 1", busy_o);
        end
        if (ready_pct == 100) begin
            n_tests++;
            if (last_cyc - first_cyc != NPIX - 1) begin
                n_fail++;
                $display("FAIL throughput: got %0d cycles want %0d", last_cyc - first_cyc + 1, NPIX);
            end
        end
        if (early_res) begin
            n_tests++;
            if (rv_seen || result_o !== res_before) begin
                n_fail++;
                $display("FAIL early_res: got pulse=%b result=%h want pulse=0 result=%h",
                         rv_seen, result_o, res_before);
            end
        end
    endtask

    // Call at the negedge just after the last handshake (t=0). The result
    // strobe is driven at t=delay.
    task automatic finish_result(input int delay, input logic [7:0] val);
        bit to_seen = 1'b0;
        for (int t = 0; t < delay; t++) begin
            if (timeout_o === 1'b1) to_seen = 1'b1;
            @(negedge clk);
        end
        res_valid_i = 1'b1;
        res_i       = val;
        @(negedge clk);
        res_valid_i = 1'b0;
        res_i       = 8'($urandom);
        n_tests++;
        if (result_valid_o !== 1'b1 || result_o !== val) begin
            n_fail++;
            $display("FAIL result_capture: got valid=%b result=%h want 1 %h", result_valid_o, result_o, val);
        end
        n_tests++;
        if (busy_o !== 1'b0 || timeout_o !== 1'b0 || to_seen) begin
            n_fail++;
            $display("FAIL result_done: got busy=%b timeout=%b early_to=%b want 0 0 0", busy_o, timeout_o, to_seen);
        end
        @(negedge clk);
        n_tests++;
        if (result_valid_o !== 1'b0 || result_o !== val) begin
            n_fail++;
            $display("FAIL result_pulse: got valid=%b result=%h want 0 %h", result_valid_o, result_o, val);
        end
    endtask

    task automatic wait_timeout();
        logic [7:0] old;
        bit         seen = 1'b0;
        old = result_o;
        for (int t = 0; t < TO; t++) begin
            if (timeout_o === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        n_tests++;
        if (seen) begin
            n_fail++; $display("FAIL timeout_early: got pulse before %0d cycles want none", TO);
        end
        n_tests++;
        if (timeout_o !== 1'b1 || busy_o !== 1'b0 || result_valid_o !== 1'b0 || result_o !== old) begin
            n_fail++;
            $display("FAIL timeout_fire: got to=%b busy=%b rv=%b result=%h want 1 0 0 %h",
                     timeout_o, busy_o, result_valid_o, result_o, old);
        end
        @(negedge clk);
        n_tests++;
        if (timeout_o !== 1'b0) begin
            n_fail++; $display("FAIL timeout_pulse: got %b want 0", timeout_o);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_tests++;
        if ({busy_o, pif.pix_valid, pif.pix_sof, pif.pix_eol, pif.pix_last,
             pif.pix_data, result_o, result_valid_o, timeout_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b valid=%b data=%h result=%h want all 0",
                     busy_o, pif.pix_valid, pif.pix_data, result_o);
        end
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (busy_o !== 1'b0 || pif.pix_valid !== 1'b0) begin
            n_fail++; $display("FAIL idle_after_reset: got busy=%b valid=%b want 0 0", busy_o, pif.pix_valid);
        end
    endtask

    task automatic test_ramp_ready_high();
        load_frame(1'b1);
        run_stream(100, 1'b0, 1'b0, -1, 1'b0);
        finish_result(10, 8'd3);
    endtask

    task automatic test_backpressure_timeout();
        run_stream(50, 1'b0, 1'b0, -1, 1'b0);
        wait_timeout();
    endtask

    task automatic test_result_timeout_tie();
        load_frame(1'b0);
        run_stream(70, 1'b0, 1'b0, -1, 1'b0);
        finish_result(TO - 1, 8'h77);
    endtask

    task automatic test_ignore_while_busy();
        bit bad = 1'b0;
        run_stream(60, 1'b1, 1'b0, -1, 1'b0);
        start_i     = 1'b1;
        load_we_i   = 1'b1;
        load_addr_i = AW'(5);
        load_data_i = ~ref_mem[5];
        @(negedge clk);
        start_i   = 1'b0;
        load_we_i = 1'b0;
        finish_result(4, 8'hA5);
        repeat (3) begin
            @(negedge clk);
            if (busy_o !== 1'b0 || pif.pix_valid !== 1'b0) bad = 1'b1;
        end
        n_tests++;
        if (bad) begin
            n_fail++; $display("FAIL start_in_wait: got activity after done want idle");
        end
        // Readback: the frame must be unchanged. Pixel 0 is rewritten in the
        // same cycle as start, so the new value must be streamed.
        run_stream(100, 1'b0, 1'b0, -1, 1'b1);
        finish_result(1, 8'h5A);
    endtask

    task automatic test_reset_midstream();
        did_reset = 1'b0;
        run_stream(60, 1'b0, 1'b1, 700, 1'b0);
        n_tests++;
        if (!did_reset) begin
            n_fail++; $display("FAIL reset_reached: got no reset at beat 700 want reset");
        end
        run_stream(80, 1'b0, 1'b1, -1, 1'b0);
        finish_result(7, 8'($urandom));
    endtask

    initial begin
        rst           = 1'b1;
        load_we_i     = 1'b0;
        load_addr_i   = '0;
        load_data_i   = '0;
        start_i       = 1'b0;
        res_i         = '0;
        res_valid_i   = 1'b0;
        pif.pix_ready = 1'b0;

        test_reset();
        test_ramp_ready_high();
        test_backpressure_timeout();
        test_result_timeout_tie();
        test_ignore_while_busy();
        test_reset_midstream();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
